// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop line synchroniser, start-bit qualify, 8 data bits LSB-first sampled mid-bit, stop check.
// Latency: o_valid / error pulse lands in the cycle after the stop-bit sample point.
// Backpressure: none; the sink must accept each one-cycle o_valid pulse as it occurs.
//
// Ports:
//   clk            - sole clock, rising edge
//   i_reset        - synchronous active-high reset
//   i_rx           - asynchronous serial line, idles high
//   o_data         - last good byte, held until the next good byte
//   o_valid        - one-cycle pulse when o_data updates
//   o_frame_error  - one-cycle pulse when the stop bit is sampled low
//   o_parity_error - one-cycle pulse on even-parity mismatch (constant 0 unless UART_RX_PARITY_EN)
//   o_busy         - high whenever the FSM is not in IDLE
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_parity_error,
  output logic       o_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          parity_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad     = ^{shift, par_bit};
  assign o_parity_error = perr_q;
`else
  assign parity_bad     = 1'b0;
  assign o_parity_error = 1'b0;
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state         <= IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      perr_q        <= 1'b0;
`endif
    end else begin
      rx_meta       <= i_rx;
      rx_s          <= rx_meta;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            // LSB arrives first, so shift right and insert at the top.
            shift <= {rx_s, shift[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            // Framing error outranks parity error.
            if (!rx_s) begin
              o_frame_error <= 1'b1;
              state         <= WAIT_IDLE;
            end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_q <= 1'b1;
`endif
              state  <= IDLE;
            end else begin
              o_data  <= shift;
              o_valid <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line is released so a break is not seen as a start.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: per-cycle line/reset waveform, frame-level reference model, per-cycle output compare.
// Latency: model schedules output pulses one cycle after each stop-bit sample point.
// Backpressure: none; outputs are observed every cycle.
module tb_uart_receiver;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  localparam int N    = 8000;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = PAR ? 11 * C : 10 * C;   // start + data (+ parity) + stop

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_error;
  logic       o_parity_error;
  logic       o_busy;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_rx           (i_rx),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_frame_error  (o_frame_error),
    .o_parity_error (o_parity_error),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // Stimulus waveform: value driven during cycle c.
  logic       line [N];
  logic       rst  [N];
  // Expected outputs during cycle c.
  bit         exp_valid [N];
  bit         exp_ferr  [N];
  bit         exp_perr  [N];
  bit         exp_busy  [N];
  logic [7:0] exp_data  [N];
  bit         dset      [N];
  logic [7:0] dval      [N];

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc_now, obs, expv);
    end
  endtask

  // Synchronised line as the receiver sees it: two cycles of delay, forced high
  // for two cycles after any reset.
  function automatic logic rxs(input int c);
    if (c < 2) return 1'b1;
    if (rst[c-1] || rst[c-2]) return 1'b1;
    return line[c-2];
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b && i < N; i++)
      if (rst[i]) return i;
    return -1;
  endfunction

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b && i < N; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic set_data(input int c, input logic [7:0] v);
    if (c < N) begin
      dset[c] = 1'b1;
      dval[c] = v;
    end
  endtask

  // Frame-level reference: find start edges, apply the sample-time rules,
  // and post the outcome one cycle after the stop sample.
  task automatic build_model();
    int c, s, ts, sp, r, w;
    logic [7:0] b;
    logic p;
    logic [7:0] cur;
    for (int i = 0; i < N; i++) begin
      exp_valid[i] = 0; exp_ferr[i] = 0; exp_perr[i] = 0; exp_busy[i] = 0; dset[i] = 0; dval[i] = '0;
    end
    c = 1;
    while (c < N) begin
      if (rst[c]) begin
        set_data(c + 1, 8'h00);
        c++;
      end else if (rxs(c)) begin
        c++;
      end else begin
        s  = c;
        ts = s + HALF;
        if (s + HALF + FL + 2 >= N) break;
        r = first_rst(s, ts);
        if (r >= 0) begin
          set_busy(s + 1, r); set_data(r + 1, 8'h00); c = r + 1;
        end else if (rxs(ts)) begin
          set_busy(s + 1, ts); c = ts + 1;
        end else begin
          sp = ts + (PAR ? 10 : 9) * C;
          r = first_rst(s, sp);
          if (r >= 0) begin
            set_busy(s + 1, r); set_data(r + 1, 8'h00); c = r + 1;
          end else begin
            for (int k = 0; k < 8; k++) b[k] = rxs(ts + (k + 1) * C);
            p = PAR ? rxs(ts + 9 * C) : 1'b0;
            set_busy(s + 1, sp);
            if (!rxs(sp)) begin
              exp_ferr[sp + 1] = 1'b1;
              w = sp + 1;
              while (w < N && !rxs(w) && !rst[w]) begin
                exp_busy[w] = 1'b1;
                w++;
              end
              if (w < N) begin
                exp_busy[w] = 1'b1;
                if (rst[w]) set_data(w + 1, 8'h00);
              end
              c = w + 1;
            end else if (PAR && ((^b) != p)) begin
              exp_perr[sp + 1] = 1'b1;
              c = sp + 1;
            end else begin
              exp_valid[sp + 1] = 1'b1;
              set_data(sp + 1, b);
              c = sp + 1;
            end
          end
        end
      end
    end
    cur = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (dset[i]) cur = dval[i];
      exp_data[i] = cur;
    end
  endtask

  // Write one frame into the waveform starting at cycle t; stop_low > 0 holds
  // the stop bit low for that many cycles instead of a normal high stop bit.
  task automatic put_frame(input int t, input logic [7:0] b, input logic pbit,
                           input int stop_low, output int t_end);
    int p;
    for (int i = 0; i < C; i++) line[t + i] = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < C; i++) line[t + (k + 1) * C + i] = b[k];
    p = t + 9 * C;
    if (PAR) begin
      for (int i = 0; i < C; i++) line[p + i] = pbit;
      p += C;
    end
    if (stop_low > 0) begin
      for (int i = 0; i < stop_low; i++) line[p + i] = 1'b0;
      t_end = p + stop_low;
    end else begin
      t_end = p + C;
    end
  endtask

  int t, te, rcyc, kind, glen;
  logic [7:0] rb;
  int dut_valids, exp_valids;

  initial begin
    for (int i = 0; i < N; i++) begin
      line[i] = 1'b1;
      rst[i]  = 1'b0;
    end
    rst[0] = 1'b1;

    // Single byte after 40 idle cycles.
    put_frame(40, 8'hA5, ^8'hA5, 0, te);
    // Short glitch.
    for (int i = 260; i < 263; i++) line[i] = 1'b0;
    // Framing error with stop held low for 30 cycles.
    put_frame(300, 8'h3C, ^8'h3C, 30, te);
    // Back-to-back frames with no idle gap.
    t = te + 40;
    put_frame(t, 8'h00, 1'b0, 0, te);
    put_frame(te, 8'hFF, 1'b0, 0, te);
    // Reset during data bit 4, rest of that frame withdrawn, then a clean frame.
    t = te + 40;
    put_frame(t, 8'h55, 1'b0, 0, te);
    rcyc = t + 5 * C + 4;
    rst[rcyc] = 1'b1;
    for (int i = rcyc + 1; i < te; i++) line[i] = 1'b1;
    put_frame(te + 40, 8'h81, 1'b0, 0, te);
    t = te + 20;
    if (PAR) begin
      put_frame(t, 8'h07, 1'b1, 0, te);
      put_frame(te + 20, 8'h07, 1'b0, 0, te);
      t = te + 20;
    end

    // Randomised traffic.
    while (t < N - 600) begin
      t += $urandom_range(0, 30);
      kind = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (kind < 6) begin
        put_frame(t, rb, ^rb, 0, t);
      end else if (kind == 6) begin
        put_frame(t, rb, ~(^rb), 0, t);
      end else if (kind == 7) begin
        glen = $urandom_range(1, HALF + 2);
        for (int i = 0; i < glen; i++) line[t + i] = 1'b0;
        t += glen + 1;
      end else if (kind == 8) begin
        put_frame(t, rb, ^rb, $urandom_range(C / 2 + 2, 40), t);
      end else begin
        put_frame(t, rb, ^rb, 0, te);
        rst[t + $urandom_range(0, FL - 1)] = 1'b1;
        t = te;
      end
    end

    build_model();

    dut_valids = 0;
    exp_valids = 0;
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      i_rx    = line[c];
      i_reset = rst[c];
      @(negedge clk);
      if (c >= 1) begin
        cyc_now = c;
        chk("valid",     32'(o_valid),        32'(exp_valid[c]));
        chk("frame_err", 32'(o_frame_error),  32'(exp_ferr[c]));
        chk("par_err",   32'(o_parity_error), 32'(exp_perr[c]));
        chk("busy",      32'(o_busy),         32'(exp_busy[c]));
        chk("data",      32'(o_data),         32'(exp_data[c]));
        if (o_valid === 1'b1) dut_valids++;
        if (exp_valid[c]) exp_valids++;
      end
    end
    cyc_now = N;
    chk("valid_count", 32'(dut_valids), 32'(exp_valids));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage; the downstream counterpart of `uart_transmitter`, consuming its `o_tx` line. Synchronises the asynchronous line, detects a start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Delivers each byte as a one-cycle `o_valid` pulse with `o_data`, or flags a framing error.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Legal range is ≥ 4. Let `HALF = CLKS_PER_BIT/2`, using integer division.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `i_reset` input 1: reset, synchronous and active-high.
- `i_rx` input 1: asynchronous serial line; it idles high.
- `o_data` output 8: last good byte; holds its value until the next good byte.
- `o_valid` output 1: one-cycle pulse when `o_data` updates.
- `o_frame_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `o_parity_error` output 1: one-cycle parity-mismatch pulse. Tied 0 without `UART_RX_PARITY_EN`.
- `o_busy` output 1: high in every state except IDLE.

## Operation
- **Synchroniser:** `i_rx` passes through 2 flops. Both flops reset to 1. All FSM decisions use the synchronised output `rx_s`.
- **Counters:**
  - Bit-period counter, width `$clog2(CLKS_PER_BIT)`; cleared on every state change and on every sample.
  - Bit index, 3 bits.
- **IDLE:**
  - `rx_s`==0 → START, with counter = 0.
  - Else stay.
- **START:**
  - At counter==`HALF`-1, sample `rx_s`.
  - 0 → DATA, with index = 0.
  - 1 → IDLE. The low pulse is treated as a glitch and produces no output pulse.
- **DATA:**
  - At counter==`CLKS_PER_BIT`-1, sample `rx_s` into the shift register. Shift right, with the new bit entering at bit 7, so the first bit received lands in bit 0.
  - Index==7 → PARITY if `UART_RX_PARITY_EN`, else STOP. Otherwise index+1.
- **PARITY** (macro only): at counter==`CLKS_PER_BIT`-1, sample `rx_s` → STOP.
- **STOP:** at counter==`CLKS_PER_BIT`-1, sample `rx_s`:
  - 1 and parity OK (or parity absent) → load `o_data`, pulse `o_valid`, go to IDLE.
  - 1 and parity bad → pulse `o_parity_error` only; `o_data` is unchanged; go to IDLE.
  - 0 → pulse `o_frame_error` only; `o_data` is unchanged; go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being read as a false start.
- **Priority:** at most one of `o_valid`, `o_frame_error`, `o_parity_error` is high in any cycle. A stop bit of 0 takes priority over a parity error.
- **Reset:** on any cycle with `i_reset`=1, regardless of state (including mid-frame):
  - The next state is IDLE.
  - `o_data`=0, `o_valid`=0, `o_frame_error`=0, `o_parity_error`=0, `o_busy`=0.
  - Shift register, counters and synchroniser flops return to their reset values.

## Timing
- **Reference cycle:** let cycle S be the first cycle in which the FSM in IDLE sees `rx_s`==0. This is 2 cycles after `i_rx` is first sampled low.
- **Samples:**
  - Start bit sampled at S+`HALF`.
  - Data bit k (k = 0..7) sampled at S+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Parity bit sampled at S+`HALF`+9·`CLKS_PER_BIT`.
  - Stop bit sampled at S+`HALF`+9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- **Output pulses:**
  - `o_valid` or an error pulse is high in the single cycle after the stop sample.
  - `o_data` changes in that same cycle.
- **Back-to-back frames:** the FSM is in IDLE from the cycle after the stop sample, which is mid-stop-bit. A following start bit is therefore detected with no gap frame required.
- **`o_busy`** rises in cycle S+1 and falls in the cycle the FSM enters IDLE.
- **Mid-frame line changes:** these are ignored except at sample points. There is no oversampling vote.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - Frame is start, 8 data, 1 even-parity bit, stop.
  - Parity error when XOR of the 8 data bits and the parity bit is 1.
  - `o_parity_error` is live.
- **Undefined:**
  - Frame is start, 8 data, stop.
  - No PARITY state exists.
  - `o_parity_error` is constant 0.

## Test plan
- **Single byte 0xA5** (`CLKS_PER_BIT`=16, no parity; line idle high for 40 cycles, then one frame): `o_valid` high exactly once, at S+8+144+1, with `o_data`=0xA5. `o_busy` high from S+1 through the stop sample.
- **Glitch:** `i_rx` low for 3 cycles, then high. No output pulse of any kind; `o_busy` returns to 0 by S+9; `o_data` unchanged.
- **Frame error:** frame carrying 0x3C, stop bit held low for 30 cycles, then high.
  - `o_frame_error` pulses once; `o_valid` stays 0; `o_data` keeps its previous value.
  - `o_busy` stays high until 2 cycles after the line returns high, plus one.
- **Back-to-back:** 0x00 then 0xFF with zero idle between frames. Two `o_valid` pulses, 160 cycles apart, carrying 0x00 then 0xFF.
- **Reset mid-frame:** `i_reset` high for 1 cycle during data bit 4 of frame 0x55, then a clean 0x81 frame.
  - All outputs are 0 the cycle after reset.
  - No pulse for the aborted frame.
  - `o_valid` with 0x81.
- **Parity** (`UART_RX_PARITY_EN` defined):
  - 0x07 with parity bit 1 → `o_valid`, `o_data`=0x07.
  - 0x07 with parity bit 0 → `o_parity_error` only; `o_data` unchanged.
